// File: rtl/mt9p031_rx_pkg.sv
// rtl/mt9p031_rx_pkg.sv - shared state encoding and constants for the MT9P031 receiver
package mt9p031_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VBLANK = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam int CNT_WIDTH_DEF = 16;
    localparam int OUT_LATENCY   = 2;

endpackage

// File: rtl/mt9p031_rx_edge.sv
// rtl/mt9p031_rx_edge.sv - input register with rise/fall flags for one sensor strobe
// rise/fall describe what q will do at the next edge, so the pixel held in q knows it is the last one.
module mt9p031_rx_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;
    assign fall = ~d & q;

endmodule

// File: rtl/mt9p031_rx.sv
// rtl/mt9p031_rx.sv - MT9P031 parallel receiver: frame sync, line delimiting, size/error report
module mt9p031_rx
    import mt9p031_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk_pix,
    input  logic                  reset_pix,
    input  logic                  i_fval,
    input  logic                  i_lval,
    input  logic [DATA_WIDTH-1:0] iv_pix_data,
    input  logic                  i_lval_continuous,
    input  logic [CNT_WIDTH-1:0]  iv_exp_width,
    input  logic [CNT_WIDTH-1:0]  iv_exp_height,
    output logic                  o_fval,
    output logic                  o_lval,
    output logic [DATA_WIDTH-1:0] ov_pix_data,
    output logic                  o_line_end,
    output logic                  o_frame_start,
    output logic                  o_frame_done,
    output logic [CNT_WIDTH-1:0]  ov_frame_width,
    output logic [CNT_WIDTH-1:0]  ov_frame_height,
    output logic                  o_frame_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                  fval_r, fval_rise, fval_fall;
    logic                  lval_r, lval_rise_unused, lval_fall;
    logic [DATA_WIDTH-1:0] data_r;

    state_t                state;
    logic                  cont_q, err_q;
    logic [CNT_WIDTH-1:0]  exp_w_q, exp_h_q, pix_cnt, line_cnt;
    logic                  done_pend, err_pend;
    logic [CNT_WIDTH-1:0]  height_pend;

    logic                  acc, line_end_now, leftover, line_bump, line_err, sat_err;
    logic [CNT_WIDTH-1:0]  pix_inc, line_inc, line_next;

    mt9p031_rx_edge u_fval_edge (
        .clk  (clk_pix),
        .rst  (reset_pix),
        .d    (i_fval),
        .q    (fval_r),
        .rise (fval_rise),
        .fall (fval_fall)
    );

    mt9p031_rx_edge u_lval_edge (
        .clk  (clk_pix),
        .rst  (reset_pix),
        .d    (i_lval),
        .q    (lval_r),
        .rise (lval_rise_unused),
        .fall (lval_fall)
    );

    always_ff @(posedge clk_pix or posedge reset_pix) begin
        if (reset_pix) begin
            data_r <= '0;
        end else begin
            data_r <= iv_pix_data;
        end
    end

    // A trailing partial line in continuous mode has no pixel left to tag, so it is counted as "leftover".
    always_comb begin
        acc       = (state == S_ACTIVE) && fval_r && lval_r;
        pix_inc   = (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + CNT_ONE;
        line_inc  = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + CNT_ONE;
        if (cont_q) begin
            line_end_now = acc && ((pix_inc == exp_w_q) || fval_fall);
        end else begin
            line_end_now = acc && (lval_fall || fval_fall);
        end
        leftover  = (state == S_ACTIVE) && fval_fall && !acc && (pix_cnt != '0);
        line_bump = line_end_now || leftover;
        line_err  = (line_end_now && (pix_inc != exp_w_q)) || leftover;
        sat_err   = (acc && (pix_cnt == CNT_MAX)) || (line_bump && (line_cnt == CNT_MAX));
        line_next = line_bump ? line_inc : line_cnt;
    end

    always_ff @(posedge clk_pix or posedge reset_pix) begin
        if (reset_pix) begin
            state           <= S_IDLE;
            cont_q          <= 1'b0;
            err_q           <= 1'b0;
            exp_w_q         <= '0;
            exp_h_q         <= '0;
            pix_cnt         <= '0;
            line_cnt        <= '0;
            done_pend       <= 1'b0;
            err_pend        <= 1'b0;
            height_pend     <= '0;
            o_fval          <= 1'b0;
            o_lval          <= 1'b0;
            ov_pix_data     <= '0;
            o_line_end      <= 1'b0;
            o_frame_start   <= 1'b0;
            o_frame_done    <= 1'b0;
            ov_frame_width  <= '0;
            ov_frame_height <= '0;
            o_frame_err     <= 1'b0;
        end else begin
            o_fval        <= (state == S_ACTIVE) && fval_r;
            o_lval        <= acc;
            ov_pix_data   <= acc ? data_r : '0;
            o_line_end    <= line_end_now;
            o_frame_start <= (state == S_ACTIVE) && !o_fval;
            o_frame_done  <= done_pend;
            done_pend     <= 1'b0;
            if (done_pend) begin
                ov_frame_height <= height_pend;
                o_frame_err     <= err_pend;
            end
            if (line_end_now) begin
                ov_frame_width <= pix_inc;
            end

            case (state)
                S_IDLE: begin
                    if (!fval_r && !i_fval) begin
                        state <= S_VBLANK;
                    end
                end
                S_VBLANK: begin
                    if (fval_rise) begin
                        state    <= S_ACTIVE;
                        cont_q   <= i_lval_continuous;
                        exp_w_q  <= iv_exp_width;
                        exp_h_q  <= iv_exp_height;
                        pix_cnt  <= '0;
                        line_cnt <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (acc) begin
                        pix_cnt <= line_end_now ? '0 : pix_inc;
                    end
                    if (line_bump) begin
                        line_cnt <= line_inc;
                    end
                    if (line_err || sat_err) begin
                        err_q <= 1'b1;
                    end
                    if (fval_fall) begin
                        state       <= S_VBLANK;
                        pix_cnt     <= '0;
                        done_pend   <= 1'b1;
                        height_pend <= line_next;
                        err_pend    <= err_q || line_err || sat_err || (line_next != exp_h_q);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mt9p031_rx.md
# mt9p031_rx

Receive-side front end for the MT9P031 parallel pixel interface: samples `fval`/`lval`/pixel bus in the pixel clock domain, discards any frame already in progress at reset release, delimits lines (from `lval` edges, or by count when the sensor holds `lval` high for the whole frame) and re-emits a clean, registered pixel stream. At each frame end it reports measured width, measured height and an error flag against programmed expectations. Sits directly behind the sensor pads, ahead of the pixel pipeline; its bench is driven by the MT9P031 sensor model BFM.

## Interface
- `DATA_WIDTH`, 10: pixel bus width (8/10/12, max 16)
- `CNT_WIDTH`, 16: width of pixel/line counters and measurement outputs
- `clk_pix`  in  1  pixel clock; all logic on rising edge
- `reset_pix`  in  1  reset; asynchronous, active-high
- `i_fval`  in  1  sensor frame valid
- `i_lval`  in  1  sensor line valid
- `iv_pix_data`  in  DATA_WIDTH  sensor pixel data
- `i_lval_continuous`  in  1  1 = `lval` stays high through the frame; lines are delimited by count. Sampled only at frame start.
- `iv_exp_width`  in  CNT_WIDTH  expected pixels per line; must be ≥1
- `iv_exp_height`  in  CNT_WIDTH  expected lines per frame
- `o_fval`  out  1  frame valid, aligned to the output data
- `o_lval`  out  1  pixel valid, aligned to the output data
- `ov_pix_data`  out  DATA_WIDTH  pixel out; holds 0 while `o_lval`=0
- `o_line_end`  out  1  one-cycle pulse on the last pixel of each line
- `o_frame_start`  out  1  one-cycle pulse on the first `o_fval`=1 cycle
- `o_frame_done`  out  1  one-cycle pulse on the first cycle after `o_fval` falls
- `ov_frame_width`  out  CNT_WIDTH  pixel count of the last completed line; updated at each line end
- `ov_frame_height`  out  CNT_WIDTH  line count of the last frame; updated with `o_frame_done`
- `o_frame_err`  out  1  error status of the last frame; updated with `o_frame_done`

## Operation
- Input stage: one register on `i_fval`, `i_lval` and `iv_pix_data`. Edge detection runs on the registered values.
- States:
  - S_IDLE (reset state): wait for registered `fval`=0, then go to S_VBLANK. A frame already active at reset release is never forwarded.
  - S_VBLANK: on `fval` rise, go to S_ACTIVE. Latch `i_lval_continuous`, `iv_exp_width` and `iv_exp_height` for the frame. Clear the pixel counter, line counter and error flag.
  - S_ACTIVE: on `fval` fall, go to S_VBLANK.
- A pixel is accepted when registered `fval`=1 and `lval`=1. The `lval`=1 cycles while `fval`=0 are dropped and are not errors.
- Edge-delimited mode (`i_lval_continuous`=0):
  - A line ends on the last accepted pixel before an `lval` fall, or before an `fval` fall if `lval` is still high.
  - If the pixel count ≠ expected width, set the frame error.
  - Then increment the line count and clear the pixel count.
- Continuous mode: a line ends when the pixel count reaches the expected width. If `fval` falls with a nonzero partial count, that partial line counts as a line and sets the frame error.
- At `fval` fall: if the line count ≠ expected height, set the frame error. Then publish the height and error outputs.
- A stall mid-line (`lval` drops, then resumes) ends the line early in edge mode. This is a short line, so it sets the error.
- Counters saturate at all-ones. Saturation sets the frame error.

## Timing
- Latency: input `lval`/data to `o_lval`/`ov_pix_data` is 2 `clk_pix` cycles. `o_fval` has the same 2-cycle delay from `i_fval`.
- `o_line_end` coincides with the final `o_lval` pixel of the line.
- `o_frame_start` coincides with the first `o_fval`=1 cycle. `o_frame_done` fires one cycle after the last `o_fval`=1 cycle.
- In S_IDLE, `o_fval` and `o_lval` are forced to 0.
- Reset values: all outputs 0, state S_IDLE.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). No `o_frame_done` pulse is issued for that frame.
- `fval` rise and `lval` rise on the same cycle: the first pixel is accepted on that cycle.
- `fval` fall and `lval` fall on the same cycle: a single line end, then the frame end.

## Structure
- Shared package `mt9p031_rx_pkg` holds:
  - state encoding S_IDLE / S_VBLANK / S_ACTIVE
  - default `CNT_WIDTH`
  - the output-latency constant (2), for bench alignment
- One sub-module, `mt9p031_rx_edge`: registered rise/fall detector, instanced for `fval` and for `lval`. Counters and the FSM stay in the top level.

## Test plan
- 16×16 frames, edge mode, expected 16/16, 20 frames:
  - 256 `o_lval` pixels per frame, 16 `o_line_end` pulses
  - data matches the input delayed 2 cycles
  - width 16, height 16, `o_frame_err`=0
- Continuous mode (`lval` held high), 16×16, expected 16/16: 16 `o_line_end` pulses, one every 16 pixels; height 16; error 0.
- `pause_high` for 200 cycles mid-line in edge mode, 16×16: the interrupted line is split into two short lines; height 17; `o_frame_err`=1; the next clean frame reports error 0.
- Reset released while the sensor is mid-frame: no `o_fval` until the following `fval` rise; the first `o_frame_done` reports 16×16 with error 0.
- Expected height programmed as 15 with a 16-line sensor: height 16, `o_frame_err`=1.
- `reset_pix` asserted at pixel 100 of a frame: all outputs are 0 within the same cycle; no `o_frame_done` for that frame.
